multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control sequencer for the RISC-V core datapath. Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB states, and handshakes with instruction/data memory via `mem_req`/`mem_ready`. Generates per-state datapath enables, including the `U_control` select for LUI, AUIPC and JAL. Sits between the decode stage (`opcode_out_d`) and the shared register file, ALU, PC and memory port.

## Interface
- `RESET_STATE`, default 0 (FETCH): state entered on reset.
- `clk`  in  1  system clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode_out_d`  in  7  opcode of the instruction in IR. Valid from DECODE onward.
- `branch_taken`  in  1  ALU compare result. Sampled in EXECUTE.
- `mem_ready`  in  1  memory completes the current `mem_req` this cycle.
- `pc_we`  out  1  PC write enable.
- `pc_sel`  out  2  selects the next PC: 00 = pc+4, 01 = pc+imm (branch/JAL), 10 = ALU result (JALR).
- `ir_we`  out  1  instruction register load.
- `reg_we`  out  1  register-file write enable.
- `wb_sel`  out  2  write-back source: 00 = ALU, 01 = memory, 10 = pc+4.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  store qualifier. Valid only while `mem_req`=1.
- `U_control`  out  2  selects the U/J datapath: 00 = none, 01 = LUI, 10 = AUIPC, 11 = JAL.
- `illegal`  out  1  unsupported opcode trapped. Sticky.
- `state`  out  3  current state: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEM, 4 WB, 5 TRAP.
- `instret`  out  32  retired-instruction count. Present only with `MCTRL_INSTRET_EN`.

## Operation
- Opcode classes:
  - R: 0110011
  - I: 0010011
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - JAL: 1101111
  - JALR: 1100111
  - LUI: 0110111
  - AUIPC: 0010111
  - SYSTEM: 1110011, executed as a NOP
  - Any other opcode is illegal.
- Transitions:
  - FETCH→DECODE when `mem_ready`=1; otherwise stay in FETCH.
  - DECODE→TRAP if the opcode is illegal; otherwise DECODE→EXECUTE.
  - EXECUTE→MEM for LOAD and STORE; otherwise EXECUTE→WB.
  - MEM→WB when `mem_ready`=1; otherwise stay in MEM.
  - WB→FETCH always.
  - TRAP is absorbing; only `rst` leaves it.
- Outputs are Moore-decoded from the registered state and the latched class. `ir_we` is the exception: it is combinational `FETCH & mem_ready`.
- Per-state outputs:
  - FETCH: `mem_req`=1, `mem_we`=0.
  - MEM: `mem_req`=1; `mem_we`=1 for STORE.
  - WB: `pc_we`=1.
  - WB, `reg_we`=1 for R, I, LOAD, JAL, JALR, LUI and AUIPC. It is 0 for STORE, BRANCH and SYSTEM.
  - WB, `wb_sel` is 01 for LOAD, 10 for JAL/JALR, and 00 otherwise.
- `pc_sel` in WB:
  - 01 for JAL, or for BRANCH with `branch_taken` latched 1 in EXECUTE.
  - 10 for JALR.
  - 00 otherwise.
- `U_control` is driven from EXECUTE through WB of the same instruction, and is 00 in all other states.
- The opcode class is latched on DECODE exit. Later changes on `opcode_out_d` are ignored until the next DECODE.
- `illegal` is set on entry to TRAP. In TRAP, every enable is 0.

## Timing
- On reset, every output is 0, `state`=FETCH and `instret`=0.
- `rst` asserted mid-operation forces FETCH immediately (asynchronous). `mem_req` drops in the same cycle; an in-flight access is abandoned.
- Minimum latency with zero memory wait: 4 cycles for non-memory instructions (F, D, E, W); 5 cycles for LOAD/STORE.
- Each wait cycle with `mem_ready`=0 adds one cycle in FETCH or MEM. `mem_req` stays high and stable throughout.
- `mem_ready` asserted while `mem_req`=0 is ignored.

## Configuration
- `MCTRL_INSTRET_EN`: when defined, a 32-bit `instret` counter increments in every WB cycle.
  - The counter wraps 0xFFFFFFFF→0.
  - It is not incremented in TRAP.
  - It is cleared by `rst`.
- When undefined, the `instret` port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then ADD (0110011), `mem_ready`=1 constant:
  - `state` 0,1,2,4,0.
  - `reg_we`=1, `wb_sel`=00, `pc_sel`=00 in the 4th cycle.
  - `instret`=1.
- LOAD with `mem_ready` low for 2 MEM cycles:
  - `mem_req`=1 and `mem_we`=0 held for 3 cycles.
  - Total latency 7 cycles.
  - WB shows `wb_sel`=01, `reg_we`=1.
- STORE, then BRANCH with `branch_taken`=1:
  - STORE: `mem_we`=1 in MEM; `reg_we`=0 in WB.
  - BRANCH: `pc_sel`=01, `reg_we`=0.
- JAL, LUI, AUIPC in turn:
  - `U_control` is 11, 01, 10 respectively during EXECUTE and WB, and 00 in FETCH.
  - JAL: `wb_sel`=10, `pc_sel`=01.
- Opcode 1010100:
  - DECODE→TRAP; `illegal`=1 and all enables 0 for 10 cycles.
  - `rst` returns to FETCH with `illegal`=0.
- Assert `rst` during MEM of a STORE: `mem_req` and `mem_we` are 0 before the next clock edge; `state`=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the RISC-V datapath.
// Steps each instruction through FETCH, DECODE, EXECUTE, (MEM), WB and
// handshakes with the shared memory port via mem_req/mem_ready.
// Optional feature macro: MCTRL_INSTRET_EN adds a 32-bit retired-instruction
// counter on port instret.
module multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_out_d,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  U_control,
  output logic        illegal,
  output logic [2:0]  state
`ifdef MCTRL_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL,
    C_JALR, C_LUI, C_AUIPC, C_SYSTEM, C_ILLEGAL
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t state_q;
  cls_t   cls_q;      // class of the instruction in flight, held from DECODE exit
  cls_t   dec_cls;    // class of the opcode currently presented
  logic   taken_q;    // branch outcome captured in EXECUTE
  logic   illegal_q;
  logic [1:0] u_sel;

  // Classify the incoming opcode; anything unlisted is illegal.
  always_comb begin
    dec_cls = C_ILLEGAL;
    case (opcode_out_d)
      OP_R:      dec_cls = C_R;
      OP_I:      dec_cls = C_I;
      OP_LOAD:   dec_cls = C_LOAD;
      OP_STORE:  dec_cls = C_STORE;
      OP_BRANCH: dec_cls = C_BRANCH;
      OP_JAL:    dec_cls = C_JAL;
      OP_JALR:   dec_cls = C_JALR;
      OP_LUI:    dec_cls = C_LUI;
      OP_AUIPC:  dec_cls = C_AUIPC;
      OP_SYSTEM: dec_cls = C_SYSTEM;
      default:   dec_cls = C_ILLEGAL;
    endcase
  end

  // Sequencer: state, latched class, latched branch outcome, sticky trap flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= state_t'(RESET_STATE);
      cls_q     <= C_SYSTEM;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          cls_q <= dec_cls;
          if (dec_cls == C_ILLEGAL) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          taken_q <= branch_taken;
          if (cls_q == C_LOAD || cls_q == C_STORE) state_q <= S_MEM;
          else                                     state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) state_q <= S_WB;
        end
        S_WB: begin
          state_q <= S_FETCH;
        end
        S_TRAP: begin
          state_q <= S_TRAP;
        end
        default: begin
          // Unused encodings fall back to a clean fetch.
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  // U/J datapath select for the latched class.
  always_comb begin
    u_sel = 2'b00;
    case (cls_q)
      C_LUI:   u_sel = 2'b01;
      C_AUIPC: u_sel = 2'b10;
      C_JAL:   u_sel = 2'b11;
      default: u_sel = 2'b00;
    endcase
  end

  // Moore decode of datapath enables from the registered state and class.
  // The memory request is masked by rst so an in-flight access drops at once.
  always_comb begin
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    U_control = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
      end
      S_EXEC: begin
        U_control = u_sel;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (cls_q == C_STORE);
        U_control = u_sel;
      end
      S_WB: begin
        pc_we     = 1'b1;
        U_control = u_sel;
        reg_we    = !(cls_q == C_STORE || cls_q == C_BRANCH || cls_q == C_SYSTEM);
        if (cls_q == C_LOAD)                        wb_sel = 2'b01;
        else if (cls_q == C_JAL || cls_q == C_JALR) wb_sel = 2'b10;
        if (cls_q == C_JAL || (cls_q == C_BRANCH && taken_q)) pc_sel = 2'b01;
        else if (cls_q == C_JALR)                             pc_sel = 2'b10;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  // IR loads on the cycle fetch data returns.
  assign ir_we   = (state_q == S_FETCH) && mem_ready && !rst;
  assign illegal = illegal_q;
  assign state   = state_q;

`ifdef MCTRL_INSTRET_EN
  // Retired-instruction counter: one per WB cycle, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 instret <= 32'd0;
    else if (state_q == S_WB) instret <= instret + 32'd1;
  end
`endif

endmodule
